// File: rtl/fetch_if.sv
// Fetch-stage bundle: instruction-memory port, hazard/redirect controls and the IF/ID register.
// Optional FETCH_MISALIGN_EN adds the sticky misalign flag.
interface fetch_if #(
  parameter int unsigned INS_ADDRESS = 32,
  parameter int unsigned INS_W       = 32
);
  logic [INS_ADDRESS-1:0] imem_addr;
  logic [INS_W-1:0]       imem_instr;
  logic                   stall;
  logic                   redirect_valid;
  logic [INS_ADDRESS-1:0] redirect_target;
  logic                   halt_req;
  logic                   id_valid;
  logic                   id_ready;
  logic [INS_W-1:0]       id_instr;
  logic [INS_ADDRESS-1:0] id_pc;
  logic [INS_ADDRESS-1:0] id_pc_next;
  logic                   halted;
`ifdef FETCH_MISALIGN_EN
  logic                   misalign;
`endif

  modport master (
    output imem_addr, id_valid, id_instr, id_pc, id_pc_next, halted,
`ifdef FETCH_MISALIGN_EN
    output misalign,
`endif
    input  imem_instr, stall, redirect_valid, redirect_target, halt_req, id_ready
  );

  modport slave (
    input  imem_addr, id_valid, id_instr, id_pc, id_pc_next, halted,
`ifdef FETCH_MISALIGN_EN
    input  misalign,
`endif
    output imem_instr, stall, redirect_valid, redirect_target, halt_req, id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID capture, redirect/stall/halt handling.
// Define FETCH_MISALIGN_EN to halt on redirects to non-word-aligned targets.
module fetch_unit #(
  parameter int unsigned            INS_ADDRESS = 32,
  parameter int unsigned            INS_W       = 32,
  parameter logic [INS_ADDRESS-1:0] RESET_PC    = '0,
  parameter int unsigned            PC_STEP     = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  fetch_if.master io_fetch
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  localparam logic [INS_ADDRESS-1:0] PcStep = INS_ADDRESS'(PC_STEP);

  state_e                 r_state, w_state_d;
  logic [INS_ADDRESS-1:0] r_pc, w_pc_d;
  logic                   r_id_valid, w_id_valid_d;
  logic [INS_W-1:0]       r_id_instr, w_id_instr_d;
  logic [INS_ADDRESS-1:0] r_id_pc, w_id_pc_d;
  logic                   w_fire;
`ifdef FETCH_MISALIGN_EN
  logic                   r_misalign, w_misalign_d;
`endif

  assign w_fire = (r_state == StRun) && !io_fetch.stall && !io_fetch.redirect_valid &&
                  !io_fetch.halt_req && (!r_id_valid || io_fetch.id_ready);

  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc;
    w_id_valid_d = r_id_valid;
    w_id_instr_d = r_id_instr;
    w_id_pc_d    = r_id_pc;
`ifdef FETCH_MISALIGN_EN
    w_misalign_d = r_misalign;
`endif
    if (r_state == StRun && io_fetch.redirect_valid) begin
      // Redirect flushes the wrong-path instruction even while stalled.
      w_id_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_EN
      if (io_fetch.redirect_target[1:0] != 2'b00) begin
        w_state_d    = StHalt;
        w_misalign_d = 1'b1;
      end else begin
        w_pc_d = io_fetch.redirect_target;
      end
`else
      w_pc_d = io_fetch.redirect_target;
`endif
    end else if (r_state == StRun && io_fetch.halt_req) begin
      w_state_d    = StHalt;
      w_id_valid_d = 1'b0;
    end else if (r_state == StRun && io_fetch.stall) begin
      w_id_valid_d = r_id_valid;
    end else if (w_fire) begin
      w_id_instr_d = io_fetch.imem_instr;
      w_id_pc_d    = r_pc;
      w_id_valid_d = 1'b1;
      w_pc_d       = r_pc + PcStep;
    end else if (r_id_valid && io_fetch.id_ready) begin
      w_id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StRun;
      r_pc       <= RESET_PC;
      r_id_valid <= 1'b0;
      r_id_instr <= '0;
      r_id_pc    <= '0;
`ifdef FETCH_MISALIGN_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_id_valid <= w_id_valid_d;
      r_id_instr <= w_id_instr_d;
      r_id_pc    <= w_id_pc_d;
`ifdef FETCH_MISALIGN_EN
      r_misalign <= w_misalign_d;
`endif
    end
  end

  assign io_fetch.imem_addr  = r_pc;
  assign io_fetch.id_valid   = r_id_valid;
  assign io_fetch.id_instr   = r_id_instr;
  assign io_fetch.id_pc      = r_id_pc;
  assign io_fetch.id_pc_next = r_id_pc + PcStep;
  assign io_fetch.halted     = (r_state == StHalt);
`ifdef FETCH_MISALIGN_EN
  assign io_fetch.misalign   = r_misalign;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, backpressure, redirect, stall, wrap, halt.
// Build with FETCH_MISALIGN_EN to exercise the misaligned-redirect halt.
module tb_fetch_unit;
  localparam logic [31:0] Key = 32'h1300_0000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  fetch_if #(.INS_ADDRESS(32), .INS_W(32)) bus ();

  fetch_unit #(
    .INS_ADDRESS(32),
    .INS_W      (32),
    .RESET_PC   (32'h0),
    .PC_STEP    (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .io_fetch(bus)
  );

  // Instruction memory returns an address-derived word.
  assign bus.imem_instr = bus.imem_addr ^ Key;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n               = 1'b0;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    bus.halt_req        = 1'b0;
    bus.id_ready        = 1'b1;
    step();
    step();
    check_eq("rst_pc",     bus.imem_addr, 32'h0);
    check_eq("rst_valid",  {31'b0, bus.id_valid}, 32'h0);
    check_eq("rst_instr",  bus.id_instr, 32'h0);
    check_eq("rst_idpc",   bus.id_pc, 32'h0);
    check_eq("rst_halted", {31'b0, bus.halted}, 32'h0);
    rst_n = 1'b1;

    // T1: consecutive fetches
    step();
    check_eq("t1_valid0", {31'b0, bus.id_valid}, 32'h1);
    check_eq("t1_idpc0",  bus.id_pc, 32'h0);
    check_eq("t1_instr0", bus.id_instr, 32'h0 ^ Key);
    check_eq("t1_next0",  bus.id_pc_next, 32'h4);
    check_eq("t1_pc0",    bus.imem_addr, 32'h4);
    step();
    check_eq("t1_idpc4",  bus.id_pc, 32'h4);
    step();
    check_eq("t1_idpc8",  bus.id_pc, 32'h8);
    check_eq("t1_instr8", bus.id_instr, 32'h8 ^ Key);

    // T2: decoder backpressure for 3 cycles
    bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t2_hold_idpc", bus.id_pc, 32'h8);
      check_eq("t2_hold_pc",   bus.imem_addr, 32'hC);
      check_eq("t2_hold_vld",  {31'b0, bus.id_valid}, 32'h1);
    end
    bus.id_ready = 1'b1;
    step();
    check_eq("t2_resume_idpc",  bus.id_pc, 32'hC);
    check_eq("t2_resume_instr", bus.id_instr, 32'hC ^ Key);
    check_eq("t2_resume_pc",    bus.imem_addr, 32'h10);

    // T3: redirect at pc=0x10 to 0x18
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h18;
    step();
    bus.redirect_valid = 1'b0;
    check_eq("t3_pc",     bus.imem_addr, 32'h18);
    check_eq("t3_bubble", {31'b0, bus.id_valid}, 32'h0);
    step();
    check_eq("t3_valid",  {31'b0, bus.id_valid}, 32'h1);
    check_eq("t3_idpc",   bus.id_pc, 32'h18);
    check_eq("t3_pc2",    bus.imem_addr, 32'h1C);

    // T4: redirect beats stall, then stall alone holds
    bus.stall           = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h40;
    step();
    bus.redirect_valid = 1'b0;
    check_eq("t4_pc",    bus.imem_addr, 32'h40);
    check_eq("t4_flush", {31'b0, bus.id_valid}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("t4_stall_pc",  bus.imem_addr, 32'h40);
      check_eq("t4_stall_vld", {31'b0, bus.id_valid}, 32'h0);
    end
    bus.stall = 1'b0;
    step();
    check_eq("t4_idpc", bus.id_pc, 32'h40);
    check_eq("t4_pc2",  bus.imem_addr, 32'h44);

    // T5: PC wrap
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    check_eq("t5_pc_top", bus.imem_addr, 32'hFFFF_FFFC);
    step();
    check_eq("t5_idpc",   bus.id_pc, 32'hFFFF_FFFC);
    check_eq("t5_next",   bus.id_pc_next, 32'h0);
    check_eq("t5_pcwrap", bus.imem_addr, 32'h0);
    check_eq("t5_instr",  bus.id_instr, 32'hFFFF_FFFC ^ Key);
    step();
    check_eq("t5_pc4",    bus.imem_addr, 32'h4);

    // T6: enter HALT
`ifdef FETCH_MISALIGN_EN
    check_eq("t6_mis_pre", {31'b0, bus.misalign}, 32'h0);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h1E;
    step();
    bus.redirect_valid = 1'b0;
    check_eq("t6_misalign", {31'b0, bus.misalign}, 32'h1);
`else
    bus.halt_req = 1'b1;
    step();
    bus.halt_req = 1'b0;
`endif
    check_eq("t6_halted", {31'b0, bus.halted}, 32'h1);
    check_eq("t6_pc",     bus.imem_addr, 32'h4);
    check_eq("t6_valid",  {31'b0, bus.id_valid}, 32'h0);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h80;
    step();
    step();
    bus.redirect_valid = 1'b0;
    check_eq("t6_ign_redir", bus.imem_addr, 32'h4);
    check_eq("t6_still_hlt", {31'b0, bus.halted}, 32'h1);
    check_eq("t6_no_fetch",  {31'b0, bus.id_valid}, 32'h0);

    // Async reset leaves HALT
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst2_halted", {31'b0, bus.halted}, 32'h0);
    check_eq("rst2_pc",     bus.imem_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
